rsa_job_scheduler: RTL

//  Shares one rsa_unit between two requesters (host-side register bank, test/BIST port).

---
 rtl/rsa_pkg.sv | 14 +
 rtl/rr_arb2.sv | 35 +++
 rtl/rsa_job_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA job scheduler: scheduler FSM encoding and requester count.
package rsa_pkg;

  localparam int unsigned N_REQ = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request vector and the index
// of the last requester served. The pointer register itself lives in the scheduler.
module rr_arb2
  import rsa_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             rr_ptr_i,
  output logic             valid_o,
  output logic             grant_idx_o,
  output logic [N_REQ-1:0] grant_oh_o
);

  always_comb begin
    valid_o     = 1'b1;
    grant_idx_o = 1'b0;
    unique case (req_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      // Contention: the requester that was not served last goes next.
      2'b11:   grant_idx_o = ~rr_ptr_i;
      default: begin
        valid_o     = 1'b0;
        grant_idx_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    grant_oh_o = '0;
    if (valid_o) begin
      grant_oh_o = grant_idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one rsa_unit between two requesters: arbitrates, latches operands, sequences en/clear
// and returns C with a one-cycle done pulse. Optional RUN watchdog under RSA_TIMEOUT_EN.
module rsa_job_scheduler
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_p,
  input  logic [N_REQ*WIDTH-1:0] op_e,
  input  logic [N_REQ*WIDTH-1:0] op_m,
  input  logic [N_REQ*WIDTH-1:0] op_const,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic                   rsa_en,
  output logic                   rsa_clear,
  output logic [WIDTH-1:0]       rsa_p,
  output logic [WIDTH-1:0]       rsa_e,
  output logic [WIDTH-1:0]       rsa_m,
  output logic [WIDTH-1:0]       rsa_const,
  input  logic [WIDTH-1:0]       rsa_c,
  input  logic                   rsa_eoc
);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, const_q, const_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             timeout;

  logic             arb_valid;
  logic             arb_idx;
  logic [N_REQ-1:0] arb_oh;

  rr_arb2 u_arb (
    .req_i      (req),
    .rr_ptr_i   (rr_ptr_q),
    .valid_o    (arb_valid),
    .grant_idx_o(arb_idx),
    .grant_oh_o (arb_oh)
  );

`ifdef RSA_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == RUN) && (cnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = '0;
    end else if (state_q == RUN && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    p_d      = p_q;
    e_d      = e_q;
    m_d      = m_q;
    const_d  = const_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_oh;
          p_d     = arb_idx ? op_p[2*WIDTH-1:WIDTH]     : op_p[WIDTH-1:0];
          e_d     = arb_idx ? op_e[2*WIDTH-1:WIDTH]     : op_e[WIDTH-1:0];
          m_d     = arb_idx ? op_m[2*WIDTH-1:WIDTH]     : op_m[WIDTH-1:0];
          const_d = arb_idx ? op_const[2*WIDTH-1:WIDTH] : op_const[WIDTH-1:0];
          state_d = LOAD;
        end
      end
      // en low for a cycle so the core restarts from its reset state.
      LOAD:  state_d = CLEAR;
      // eoc here is stale from a previous job and is deliberately ignored.
      CLEAR: state_d = RUN;
      RUN: begin
        if (rsa_eoc) begin
          result_d = rsa_c;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (timeout) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = grant_q[1];
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= 1'b1;
      p_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      const_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      p_q      <= p_d;
      e_q      <= e_d;
      m_q      <= m_d;
      const_q  <= const_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign done      = (state_q == DONE) ? grant_q : '0;
  assign err       = err_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);
  assign rsa_en    = (state_q == CLEAR) || (state_q == RUN);
  assign rsa_clear = (state_q == CLEAR);
  assign rsa_p     = p_q;
  assign rsa_e     = e_q;
  assign rsa_m     = m_q;
  assign rsa_const = const_q;

endmodule
